// File: rtl/ex_alu_sequencer_if.sv
// Bundle of upstream, ALU-control, memory-stage and redirect signals for the execute-stage sequencer.
// master: the sequencer itself; slave: the surrounding pipeline and ALU datapath.
interface ex_alu_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [1:0]        in_cond;
  logic [12:0]       in_alu_cfg;
  logic [12:0]       alu_cfg;
  logic              pass;
  logic              tgt_sel;
  logic [15:0]       alu_out;
  logic              alu_zero;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       res_q;
  logic              redirect;
  logic [15:0]       redirect_pc;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    input  in_valid, in_kind, in_cond, in_alu_cfg, alu_out, alu_zero, out_ready,
    output in_ready, alu_cfg, pass, tgt_sel, out_valid, res_q, redirect, redirect_pc, taken_cnt
  );

  modport slave (
    output in_valid, in_kind, in_cond, in_alu_cfg, alu_out, alu_zero, out_ready,
    input  in_ready, alu_cfg, pass, tgt_sel, out_valid, res_q, redirect, redirect_pc, taken_cnt
  );
endinterface

// File: rtl/ex_alu_sequencer.sv
// Time-shares the execute ALU between the data pass and the branch/jump target add,
// evaluates branch conditions and issues a one-cycle PC redirect.
module ex_alu_sequencer #(
  parameter logic [2:0]  OP_ADD = 3'b100,
  parameter int unsigned CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  ex_alu_sequencer_if.master bus
);

  typedef enum logic {StIdle, StTgt} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      res_q, res_d;
  logic             redirect_q, redirect_d;
  logic [15:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             taken_q, taken_d;
  logic             tgt_sel_q, tgt_sel_d;

  logic free;
  logic cond_hit;
  logic taken;

  assign free = !out_valid_q || bus.out_ready;

  // Decode sets up the data pass to forward Rs, so flags/sign reflect the register value.
  always_comb begin
    cond_hit = 1'b0;
    unique case (bus.in_cond)
      2'b00: cond_hit = bus.alu_zero;
      2'b01: cond_hit = !bus.alu_zero;
      2'b10: cond_hit = bus.alu_out[15];
      2'b11: cond_hit = !bus.alu_out[15];
    endcase
  end

  assign taken = bus.in_kind[1] || ((bus.in_kind == 2'b01) && cond_hit);

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q && !bus.out_ready;
    res_d         = res_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    taken_cnt_d   = taken_cnt_q;
    taken_d       = taken_q;
    tgt_sel_d     = tgt_sel_q;
    bus.in_ready  = 1'b0;
    bus.pass      = 1'b0;
    bus.alu_cfg   = bus.in_alu_cfg;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && free) begin
          res_d       = bus.alu_out;
          out_valid_d = 1'b1;
          if (taken) begin
            taken_d   = 1'b1;
            tgt_sel_d = (bus.in_kind == 2'b11);
            state_d   = StTgt;
          end else begin
            bus.in_ready = 1'b1;
          end
        end
      end
      StTgt: begin
        bus.pass      = 1'b1;
        // Source muxes are forced by pass; only the op/carry/sign fields matter here.
        bus.alu_cfg   = {3'b000, 3'b000, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.in_ready  = 1'b1;
        redirect_pc_d = bus.alu_out;
        redirect_d    = 1'b1;
        taken_cnt_d   = taken_cnt_q + CNT_W'(1);
        taken_d       = 1'b0;
        state_d       = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      out_valid_q   <= 1'b0;
      res_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      taken_cnt_q   <= '0;
      taken_q       <= 1'b0;
      tgt_sel_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      res_q         <= res_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      taken_cnt_q   <= taken_cnt_d;
      taken_q       <= taken_d;
      tgt_sel_q     <= tgt_sel_d;
    end
  end

  assign bus.tgt_sel     = tgt_sel_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.res_q       = res_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Directed bench for ex_alu_sequencer; data-pass results go through a scoreboard queue
// and are compared when the memory stage accepts them.
module tb_ex_alu_sequencer;

  localparam int unsigned CntW = 4;
  localparam logic [12:0] TgtCfg = {3'b000, 3'b000, 3'b100, 4'b0001};

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];

  ex_alu_sequencer_if #(.CNT_W(CntW)) bus ();

  ex_alu_sequencer #(.OP_ADD(3'b100), .CNT_W(CntW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of inputs at the falling edge; pops the scoreboard if the result drains.
  task automatic drive(input logic v, input logic [1:0] k, input logic [1:0] c,
                       input logic [12:0] cfg, input logic [15:0] a, input logic z,
                       input logic ordy);
    logic [15:0] e;
    @(negedge clk);
    bus.in_valid   = v;
    bus.in_kind    = k;
    bus.in_cond    = c;
    bus.in_alu_cfg = cfg;
    bus.alu_out    = a;
    bus.alu_zero   = z;
    bus.out_ready  = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_res", bus.res_q, e);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_kind    = 2'b00;
    bus.in_cond    = 2'b00;
    bus.in_alu_cfg = '0;
    bus.alu_out    = '0;
    bus.alu_zero   = 1'b0;
    bus.out_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_res", bus.res_q, 16'h0);
    chk("rst_redirect", bus.redirect, 1'b0);
    chk("rst_redirect_pc", bus.redirect_pc, 16'h0);
    chk("rst_taken_cnt", bus.taken_cnt, 4'h0);
    chk("rst_pass", bus.pass, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ALU-only
    drive(1'b1, 2'b00, 2'b00, 13'h0abc, 16'h1234, 1'b0, 1'b1);
    chk("alu_in_ready", bus.in_ready, 1'b1);
    chk("alu_pass", bus.pass, 1'b0);
    chk("alu_cfg_data", bus.alu_cfg, 13'h0abc);
    exp_q.push_back(16'h1234);
    drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
    chk("alu_out_valid", bus.out_valid, 1'b1);
    chk("alu_redirect", bus.redirect, 1'b0);

    // BEQZ taken
    drive(1'b1, 2'b01, 2'b00, 13'h0123, 16'h0000, 1'b1, 1'b1);
    chk("beqz_c0_in_ready", bus.in_ready, 1'b0);
    chk("beqz_c0_pass", bus.pass, 1'b0);
    exp_q.push_back(16'h0000);
    drive(1'b1, 2'b01, 2'b00, 13'h0123, 16'h0040, 1'b0, 1'b1);
    chk("beqz_c1_pass", bus.pass, 1'b1);
    chk("beqz_c1_cfg", bus.alu_cfg, TgtCfg);
    chk("beqz_c1_in_ready", bus.in_ready, 1'b1);
    chk("beqz_c1_tgt_sel", bus.tgt_sel, 1'b0);
    chk("beqz_c1_redirect", bus.redirect, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
    chk("beqz_c2_redirect", bus.redirect, 1'b1);
    chk("beqz_c2_pc", bus.redirect_pc, 16'h0040);
    chk("beqz_c2_cnt", bus.taken_cnt, 4'h1);
    chk("beqz_c2_in_ready", bus.in_ready, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
    chk("beqz_c3_redirect", bus.redirect, 1'b0);

    // BNEZ untaken
    drive(1'b1, 2'b01, 2'b01, 13'h1555, 16'h0000, 1'b1, 1'b1);
    chk("bnez_in_ready", bus.in_ready, 1'b1);
    chk("bnez_pass", bus.pass, 1'b0);
    exp_q.push_back(16'h0000);
    drive(1'b0, 2'b00, 2'b00, 13'h1abc, 16'h0, 1'b0, 1'b1);
    chk("bnez_pass_after", bus.pass, 1'b0);
    chk("bnez_redirect", bus.redirect, 1'b0);
    chk("bnez_cnt", bus.taken_cnt, 4'h1);
    chk("idle_cfg_passthru", bus.alu_cfg, 13'h1abc);

    // JR then BLTZ taken
    drive(1'b1, 2'b11, 2'b00, 13'h0, 16'h2222, 1'b0, 1'b1);
    chk("jr_in_ready", bus.in_ready, 1'b0);
    exp_q.push_back(16'h2222);
    drive(1'b1, 2'b11, 2'b00, 13'h0, 16'h3000, 1'b0, 1'b1);
    chk("jr_pass", bus.pass, 1'b1);
    chk("jr_tgt_sel", bus.tgt_sel, 1'b1);
    drive(1'b1, 2'b01, 2'b10, 13'h0, 16'h8000, 1'b0, 1'b1);
    chk("bltz_in_ready", bus.in_ready, 1'b0);
    chk("jr_redirect", bus.redirect, 1'b1);
    chk("jr_pc", bus.redirect_pc, 16'h3000);
    exp_q.push_back(16'h8000);
    drive(1'b1, 2'b01, 2'b10, 13'h0, 16'h0100, 1'b0, 1'b1);
    chk("bltz_pass", bus.pass, 1'b1);
    chk("bltz_tgt_sel", bus.tgt_sel, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
    chk("bltz_pc", bus.redirect_pc, 16'h0100);
    chk("bltz_cnt", bus.taken_cnt, 4'h3);

    // Back-pressure, then simultaneous drain and fire
    drive(1'b1, 2'b00, 2'b00, 13'h0, 16'h5555, 1'b0, 1'b0);
    chk("bp_first_in_ready", bus.in_ready, 1'b1);
    exp_q.push_back(16'h5555);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 2'b00, 13'h0, 16'h6666, 1'b0, 1'b0);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_res_stable", bus.res_q, 16'h5555);
    end
    drive(1'b1, 2'b00, 2'b00, 13'h0, 16'h7777, 1'b0, 1'b1);
    chk("bp_accept_in_ready", bus.in_ready, 1'b1);
    exp_q.push_back(16'h7777);
    drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
    chk("bp_out_valid_kept", bus.out_valid, 1'b1);
    drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
    chk("bp_drained", bus.out_valid, 1'b0);

    // Reset while in the target pass
    drive(1'b1, 2'b10, 2'b00, 13'h0, 16'h0abc, 1'b0, 1'b1);
    exp_q.push_back(16'h0abc);
    drive(1'b1, 2'b10, 2'b00, 13'h0, 16'h0f00, 1'b0, 1'b1);
    chk("rtgt_pass_before", bus.pass, 1'b1);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rtgt_pass", bus.pass, 1'b0);
    chk("rtgt_out_valid", bus.out_valid, 1'b0);
    chk("rtgt_redirect_pc", bus.redirect_pc, 16'h0);
    chk("rtgt_cnt", bus.taken_cnt, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
      chk("rtgt_no_redirect", bus.redirect, 1'b0);
      chk("rtgt_cnt_after", bus.taken_cnt, 4'h0);
    end

    // Sixteen taken jumps wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b10, 2'b00, 13'h0, 16'(i), 1'b0, 1'b1);
      chk("wrap_cnt", bus.taken_cnt, 32'(i));
      chk("wrap_in_ready", bus.in_ready, 1'b0);
      exp_q.push_back(16'(i));
      drive(1'b1, 2'b10, 2'b00, 13'h0, 16'h0100 + 16'(i), 1'b0, 1'b1);
      chk("wrap_pass", bus.pass, 1'b1);
    end
    drive(1'b0, 2'b00, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1);
    chk("wrap_redirect", bus.redirect, 1'b1);
    chk("wrap_pc", bus.redirect_pc, 16'h010f);
    chk("wrap_cnt_zero", bus.taken_cnt, 4'h0);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
